// File: rtl/scan_dff_chain_pkg.sv
// Shared definitions for the scan register chain: cell modes, reset defaults
// and the width helper used to size the shift counter.
package scan_chain_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_LOAD  = 2'b01,
    MODE_SHIFT = 2'b10
  } mode_e;

  localparam logic DEFAULT_INIT_BIT = 1'b0;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/scan_dff_chain_if.sv
// Data/scan/status bundle of one scan register segment.
interface scan_dff_chain_if
  import scan_chain_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CNT_W = clog2(WIDTH + 1);

  logic             SE;
  logic             SI;
  logic             EN;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] QN;
  logic             SO;
  logic [CNT_W-1:0] SHIFT_CNT;
  logic             CHAIN_FULL;

  modport master (
    output SE, SI, EN, D,
    input  Q, QN, SO, SHIFT_CNT, CHAIN_FULL
  );

  modport slave (
    input  SE, SI, EN, D,
    output Q, QN, SO, SHIFT_CNT, CHAIN_FULL
  );
endinterface

// File: rtl/scan_dff_cell.sv
// Single scan flip-flop: hold, functional load or serial shift, with a
// per-cell synchronous reset value.
module scan_dff_cell
  import scan_chain_pkg::*;
#(
  parameter logic INIT_BIT = DEFAULT_INIT_BIT
) (
  input  logic  CK,
  input  logic  RSTN,
  input  mode_e MODE,
  input  logic  SI,
  input  logic  D,
  output logic  Q
);
  logic q_q;

  always_ff @(posedge CK) begin
    if (!RSTN) begin
      q_q <= INIT_BIT;
    end else begin
      unique case (MODE)
        MODE_SHIFT: q_q <= SI;
        MODE_LOAD:  q_q <= D;
        default:    q_q <= q_q;
      endcase
    end
  end

  assign Q = q_q;
endmodule

// File: rtl/scan_dff_chain.sv
// WIDTH-bit scan register segment with parallel load, serial shift and a
// saturating count of consecutive shift cycles.
module scan_dff_chain
  import scan_chain_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = {WIDTH{DEFAULT_INIT_BIT}}
) (
  input logic              CK,
  input logic              RSTN,
  scan_dff_chain_if.slave  bus
);
  localparam int unsigned      CNT_W   = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  mode_e            mode;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             se_q;

  always_comb begin
    mode = MODE_HOLD;
    if (bus.SE)      mode = MODE_SHIFT;
    else if (bus.EN) mode = MODE_LOAD;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic si_bit;
    if (i == 0) begin : g_head
      assign si_bit = bus.SI;
    end else begin : g_link
      assign si_bit = q[i-1];
    end
    scan_dff_cell #(.INIT_BIT(INIT[i])) u_cell (
      .CK   (CK),
      .RSTN (RSTN),
      .MODE (mode),
      .SI   (si_bit),
      .D    (bus.D[i]),
      .Q    (q[i])
    );
  end

  // A burst start (SE rising after a non-shift cycle) restarts the count at 1.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.SE) begin
      if (!se_q)                cnt_d = CNT_W'(1);
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CK) begin
    if (!RSTN) begin
      cnt_q <= '0;
      se_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      se_q  <= bus.SE;
    end
  end

  assign bus.Q          = q;
  assign bus.QN         = ~q;
  assign bus.SO         = q[WIDTH-1];
  assign bus.SHIFT_CNT  = cnt_q;
  assign bus.CHAIN_FULL = (cnt_q == CNT_MAX);
endmodule

// File: tb/tb_scan_dff_chain.sv
// Directed bench for scan_dff_chain: an 8-bit segment (INIT=A5) and a 1-bit
// segment (INIT=1) sharing one clock.
module tb_scan_dff_chain;
  logic CK = 1'b0;
  logic rstn8, rstn1;
  int   checks = 0;
  int   failures = 0;

  always #5 CK = ~CK;

  scan_dff_chain_if #(.WIDTH(8)) bus8 ();
  scan_dff_chain_if #(.WIDTH(1)) bus1 ();

  scan_dff_chain #(.WIDTH(8), .INIT(8'hA5)) dut8 (.CK(CK), .RSTN(rstn8), .bus(bus8.slave));
  scan_dff_chain #(.WIDTH(1), .INIT(1'b1))  dut1 (.CK(CK), .RSTN(rstn1), .bus(bus1.slave));

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset();
    rstn8 = 1'b0; bus8.SE = 1'b1; bus8.EN = 1'b1; bus8.SI = 1'b1; bus8.D = 8'hFF;
    tick(); tick();
    checks++; if (bus8.Q !== 8'hA5) begin failures++; $display("FAIL reset_q got=%h exp=a5", bus8.Q); end
    checks++; if (bus8.QN !== 8'h5A) begin failures++; $display("FAIL reset_qn got=%h exp=5a", bus8.QN); end
    checks++; if (bus8.SO !== 1'b1) begin failures++; $display("FAIL reset_so got=%b exp=1", bus8.SO); end
    checks++; if (bus8.SHIFT_CNT !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bus8.SHIFT_CNT); end
    checks++; if (bus8.CHAIN_FULL !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus8.CHAIN_FULL); end
  endtask

  task automatic test_load();
    rstn8 = 1'b1; bus8.SE = 1'b0; bus8.EN = 1'b1; bus8.D = 8'h3C; bus8.SI = 1'bx;
    tick();
    checks++; if (bus8.Q !== 8'h3C) begin failures++; $display("FAIL load_q got=%h exp=3c", bus8.Q); end
    checks++; if (bus8.SHIFT_CNT !== 4'd0) begin failures++; $display("FAIL load_cnt got=%0d exp=0", bus8.SHIFT_CNT); end
    bus8.EN = 1'b0; bus8.D = 'x;
    tick(); tick();
    checks++; if (bus8.Q !== 8'h3C) begin failures++; $display("FAIL load_hold got=%h exp=3c", bus8.Q); end
  endtask

  task automatic test_full_shift();
    logic [7:0] word;
    logic [2:0] so_exp;
    logic [7:0] q_exp;
    word = 8'hC3;
    bus8.SE = 1'b1; bus8.EN = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      bus8.SI = word[i];
      tick();
      checks++;
      if (bus8.SHIFT_CNT !== 4'(8 - i)) begin
        failures++; $display("FAIL shift_cnt step=%0d got=%0d exp=%0d", 7 - i, bus8.SHIFT_CNT, 8 - i);
      end
      if (i == 1) begin
        checks++; if (bus8.CHAIN_FULL !== 1'b0) begin failures++; $display("FAIL full_early got=%b exp=0", bus8.CHAIN_FULL); end
      end
    end
    checks++; if (bus8.Q !== 8'hC3) begin failures++; $display("FAIL shift_q got=%h exp=c3", bus8.Q); end
    checks++; if (bus8.CHAIN_FULL !== 1'b1) begin failures++; $display("FAIL full_set got=%b exp=1", bus8.CHAIN_FULL); end
    so_exp = 3'b100;
    q_exp  = 8'hC3;
    bus8.SI = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      q_exp = {q_exp[6:0], 1'b0};
      checks++; if (bus8.SO !== so_exp[2-k]) begin failures++; $display("FAIL over_so step=%0d got=%b exp=%b", k, bus8.SO, so_exp[2-k]); end
      checks++; if (bus8.SHIFT_CNT !== 4'd8 || bus8.CHAIN_FULL !== 1'b1) begin
        failures++; $display("FAIL over_sat step=%0d cnt=%0d full=%b exp cnt=8 full=1", k, bus8.SHIFT_CNT, bus8.CHAIN_FULL);
      end
    end
    checks++; if (bus8.Q !== 8'h18) begin failures++; $display("FAIL over_q got=%h exp=18", bus8.Q); end
    bus8.SE = 1'b0; bus8.SI = 1'bx;
    tick();
    checks++; if (bus8.SHIFT_CNT !== 4'd8) begin failures++; $display("FAIL idle_cnt got=%0d exp=8", bus8.SHIFT_CNT); end
    bus8.SE = 1'b1; bus8.SI = 1'b1;
    tick();
    checks++; if (bus8.SHIFT_CNT !== 4'd1) begin failures++; $display("FAIL reburst_cnt got=%0d exp=1", bus8.SHIFT_CNT); end
    checks++; if (bus8.Q !== 8'h31) begin failures++; $display("FAIL reburst_q got=%h exp=31", bus8.Q); end
  endtask

  task automatic test_priority();
    bus8.SE = 1'b0; bus8.EN = 1'b1; bus8.D = 8'h01;
    tick();
    bus8.SE = 1'b1; bus8.EN = 1'b1; bus8.D = 8'hFF; bus8.SI = 1'b0;
    tick();
    checks++; if (bus8.Q !== 8'h02) begin failures++; $display("FAIL prio_q got=%h exp=02", bus8.Q); end
    checks++; if (bus8.SHIFT_CNT !== 4'd1) begin failures++; $display("FAIL prio_cnt got=%0d exp=1", bus8.SHIFT_CNT); end
    bus8.EN = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    bus8.SE = 1'b0;
    tick();
    bus8.SE = 1'b1; bus8.SI = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    checks++; if (bus8.SHIFT_CNT !== 4'd4) begin failures++; $display("FAIL mid_cnt got=%0d exp=4", bus8.SHIFT_CNT); end
    checks++; if (bus8.Q !== 8'h2F) begin failures++; $display("FAIL mid_q got=%h exp=2f", bus8.Q); end
    rstn8 = 1'b0;
    tick();
    checks++; if (bus8.Q !== 8'hA5 || bus8.SHIFT_CNT !== 4'd0) begin
      failures++; $display("FAIL mid_reset q=%h cnt=%0d exp q=a5 cnt=0", bus8.Q, bus8.SHIFT_CNT);
    end
    rstn8 = 1'b1; bus8.SI = 1'b0;
    tick();
    checks++; if (bus8.SHIFT_CNT !== 4'd1) begin failures++; $display("FAIL mid_restart got=%0d exp=1", bus8.SHIFT_CNT); end
    checks++; if (bus8.Q !== 8'h4A) begin failures++; $display("FAIL mid_restart_q got=%h exp=4a", bus8.Q); end
    bus8.SE = 1'b0;
  endtask

  task automatic test_width1();
    rstn1 = 1'b0; bus1.SE = 1'b1; bus1.SI = 1'b0;
    tick();
    checks++; if (bus1.Q !== 1'b1 || bus1.SO !== 1'b1 || bus1.QN !== 1'b0) begin
      failures++; $display("FAIL w1_reset q=%b so=%b qn=%b exp 1 1 0", bus1.Q, bus1.SO, bus1.QN);
    end
    checks++; if (bus1.SHIFT_CNT !== 1'b0 || bus1.CHAIN_FULL !== 1'b0) begin
      failures++; $display("FAIL w1_reset_cnt cnt=%0d full=%b exp 0 0", bus1.SHIFT_CNT, bus1.CHAIN_FULL);
    end
    rstn1 = 1'b1;
    tick();
    checks++; if (bus1.Q !== 1'b0 || bus1.CHAIN_FULL !== 1'b1) begin
      failures++; $display("FAIL w1_shift q=%b full=%b exp 0 1", bus1.Q, bus1.CHAIN_FULL);
    end
    bus1.SI = 1'b1;
    tick();
    checks++; if (bus1.Q !== 1'b1 || bus1.SHIFT_CNT !== 1'b1) begin
      failures++; $display("FAIL w1_sat q=%b cnt=%0d exp 1 1", bus1.Q, bus1.SHIFT_CNT);
    end
  endtask

  initial begin
    rstn1 = 1'b0; bus1.SE = 1'b0; bus1.EN = 1'b0; bus1.SI = 1'b0; bus1.D = 1'b0;
    rstn8 = 1'b0; bus8.SE = 1'b0; bus8.EN = 1'b0; bus8.SI = 1'b0; bus8.D = 8'h00;
    #2;
    test_reset();
    test_load();
    test_full_shift();
    test_priority();
    test_reset_mid_shift();
    test_width1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
